// File: rtl/display_pkg.sv
// Shared constants and types for the two-player score scan display.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package display_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  typedef enum logic [1:0] {
    POS_ONES     = 2'd0,
    POS_TENS     = 2'd1,
    POS_HUNDREDS = 2'd2
  } pos_e;

  typedef struct packed {
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } score_t;

  // Digit index k -> owning player and decimal position; index 5 is leftmost.
  localparam logic [NUM_DIGITS-1:0]   DIG_IS_P1 = 6'b111000;
  localparam logic [2*NUM_DIGITS-1:0] DIG_POS   = {POS_HUNDREDS, POS_TENS, POS_ONES,
                                                   POS_HUNDREDS, POS_TENS, POS_ONES};

  function automatic pos_e dig_pos(input logic [2:0] idx);
    return pos_e'(DIG_POS[{idx, 1'b0} +: 2]);
  endfunction

endpackage

// File: rtl/score_scan_display_if.sv
// Score inputs and multiplexed display outputs of the scan display.
interface score_scan_display_if;
  import display_pkg::*;

  logic                  en;
  logic [3:0]            p1_hundreds;
  logic [3:0]            p1_tens;
  logic [3:0]            p1_ones;
  logic [3:0]            p2_hundreds;
  logic [3:0]            p2_tens;
  logic [3:0]            p2_ones;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  frame_start;

  modport master (
    output en, p1_hundreds, p1_tens, p1_ones, p2_hundreds, p2_tens, p2_ones,
    input  an, seg, frame_start
  );

  modport slave (
    input  en, p1_hundreds, p1_tens, p1_ones, p2_hundreds, p2_tens, p2_ones,
    output an, seg, frame_start
  );

endinterface

// File: rtl/seg7_decode.sv
// BCD to active-low 7-segment decoder; values above 9 show a dash even when blank is set.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd > 4'd9) begin
      seg = SEG_DASH;
    end else if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/score_scan_display.sv
// Six-digit multiplexed score display: P1 left, P2 right, snapshot taken once per frame.
// an/seg are registered one cycle behind the digit index; each digit is lit SCAN_DIV cycles.
module score_scan_display
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  score_scan_display_if.slave  bus
);

  logic [CNT_W-1:0]      cnt;
  logic [2:0]            idx;
  logic                  tick;
  score_t                p1_sh;
  score_t                p2_sh;
  score_t                cur;
  logic [3:0]            digit;
  logic                  blank;
  logic [6:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;
  logic                  frame_start_q;

  assign tick = bus.en && (cnt == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      idx           <= '0;
      p1_sh         <= '0;
      p2_sh         <= '0;
      an_q          <= '1;
      seg_q         <= SEG_BLANK;
      frame_start_q <= 1'b0;
    end else if (!bus.en) begin
      // Shadows deliberately keep their contents so re-enabling shows the last frame.
      cnt           <= '0;
      idx           <= '0;
      an_q          <= '1;
      seg_q         <= SEG_BLANK;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      an_q          <= ~(NUM_DIGITS'(1) << idx);
      seg_q         <= seg_nxt;
      cnt           <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) begin
        if (idx == 3'(NUM_DIGITS - 1)) begin
          idx           <= '0;
          p1_sh         <= '{bus.p1_hundreds, bus.p1_tens, bus.p1_ones};
          p2_sh         <= '{bus.p2_hundreds, bus.p2_tens, bus.p2_ones};
          frame_start_q <= 1'b1;
        end else begin
          idx <= idx + 3'd1;
        end
      end
    end
  end

  // An invalid digit is nonzero, so it never satisfies a blanking condition.
  always_comb begin
    cur   = DIG_IS_P1[idx] ? p1_sh : p2_sh;
    digit = cur.ones;
    blank = 1'b0;
    case (dig_pos(idx))
      POS_TENS: begin
        digit = cur.tens;
        blank = (cur.hundreds == 4'd0) && (cur.tens == 4'd0);
      end
      POS_HUNDREDS: begin
        digit = cur.hundreds;
        blank = (cur.hundreds == 4'd0);
      end
      default: begin
        digit = cur.ones;
        blank = 1'b0;
      end
    endcase
  end

  seg7_decode u_dec (
    .bcd   (digit),
    .blank (blank),
    .seg   (seg_nxt)
  );

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_score_scan_display.sv
// Directed bench for score_scan_display with SCAN_DIV=4; expected digits queued when scores are driven.
module tb_score_scan_display;

  localparam int SD  = 4;
  localparam int GAP = 6 * SD;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  score_scan_display_if bus();

  score_scan_display #(.SCAN_DIV(SD), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [12:0] exp_q[$];
  logic [6:0]  tb_seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [5:0]  an_tab [6] = '{6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111};

  function automatic logic [6:0] exp_seg(input logic [3:0] v, input logic lz);
    if (v > 4'd9) return 7'b0111111;
    if (lz) return 7'b1111111;
    return tb_seg_tab[v];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic push_exp(input logic [3:0] ah, at, ao, bh, bt, bo);
    logic [6:0] s [6];
    s[0] = exp_seg(bo, 1'b0);
    s[1] = exp_seg(bt, bh == 4'd0 && bt == 4'd0);
    s[2] = exp_seg(bh, bh == 4'd0);
    s[3] = exp_seg(ao, 1'b0);
    s[4] = exp_seg(at, ah == 4'd0 && at == 4'd0);
    s[5] = exp_seg(ah, ah == 4'd0);
    for (int k = 0; k < 6; k++) exp_q.push_back({an_tab[k], s[k]});
  endtask

  task automatic set_scores(input logic [3:0] ah, at, ao, bh, bt, bo);
    bus.p1_hundreds = ah; bus.p1_tens = at; bus.p1_ones = ao;
    bus.p2_hundreds = bh; bus.p2_tens = bt; bus.p2_ones = bo;
    push_exp(ah, at, ao, bh, bt, bo);
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_start !== 1'b1 && n < 100);
  endtask

  // Compares one full frame of digits starting on the next cycle; optionally changes P1 ones mid-frame.
  task automatic check_digits(input bit tear);
    logic [12:0] e;
    for (int k = 0; k < 6; k++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      for (int c = 0; c < SD; c++) begin
        @(negedge clk);
        if (tear && k == 2 && c == 0) bus.p1_ones = 4'd9;
        if (k == 0 && c == 0) chk("frame_start_one_cycle", 16'(bus.frame_start), 16'd0);
        chk($sformatf("an_digit%0d_cyc%0d", k, c), 16'(bus.an), 16'(e[12:7]));
        chk($sformatf("seg_digit%0d_cyc%0d", k, c), 16'(bus.seg), 16'(e[6:0]));
      end
    end
  endtask

  task automatic check_frame(input int gap, input bit tear);
    int n;
    wait_fs(n);
    chk("frame_start_gap", 16'(n), 16'(gap));
    check_digits(tear);
  endtask

  initial begin
    bus.en = 1'b1;
    bus.p1_hundreds = '0; bus.p1_tens = '0; bus.p1_ones = '0;
    bus.p2_hundreds = '0; bus.p2_tens = '0; bus.p2_ones = '0;

    #12;
    chk("reset_an", 16'(bus.an), 16'h003F);
    chk("reset_seg", 16'(bus.seg), 16'h007F);
    chk("reset_frame_start", 16'(bus.frame_start), 16'd0);

    @(negedge clk);
    rst_n = 1'b1;
    set_scores(4'd1, 4'd2, 4'd3, 4'd0, 4'd0, 4'd7);
    check_frame(GAP, 1'b0);

    set_scores(4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd0);
    check_frame(GAP, 1'b0);

    // P1 ones changes to 9 while digit 2 is lit; 9 appears only in the following frame.
    set_scores(4'd1, 4'd2, 4'd3, 4'd0, 4'd0, 4'd7);
    check_frame(GAP, 1'b1);
    push_exp(4'd1, 4'd2, 4'd9, 4'd0, 4'd0, 4'd7);
    check_frame(GAP, 1'b0);

    set_scores(4'hA, 4'd0, 4'd0, 4'd0, 4'hC, 4'd1);
    check_frame(GAP, 1'b0);

    repeat (6) @(negedge clk);
    bus.en = 1'b0;
    push_exp(4'hA, 4'd0, 4'd0, 4'd0, 4'hC, 4'd1);
    set_scores(4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("en_low_an_%0d", i), 16'(bus.an), 16'h003F);
      chk($sformatf("en_low_seg_%0d", i), 16'(bus.seg), 16'h007F);
      chk($sformatf("en_low_fs_%0d", i), 16'(bus.frame_start), 16'd0);
    end
    bus.en = 1'b1;
    check_digits(1'b0);
    check_frame(GAP, 1'b0);

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_an", 16'(bus.an), 16'h003F);
    chk("async_reset_seg", 16'(bus.seg), 16'h007F);
    chk("async_reset_fs", 16'(bus.frame_start), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_scores(4'd0, 4'd0, 4'd1, 4'd3, 4'd0, 4'd0);
    check_frame(GAP, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
